cdc_afifo_rd_stream: RTL and testbench

//  Read-side consumer of cdc_afifo: pops words from the FIFO read port (show-ahead data, rempty flag) in the

---
 rtl/cdc_pkg.sv | 21 ++
 rtl/cdc_skidbuf2.sv | 51 +++++
 rtl/cdc_afifo_rd_stream.sv | 78 +++++++
 tb/tb_cdc_afifo_rd_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the rclk-domain consumer of cdc_afifo.
package cdc_pkg;
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } cdc_rdstream_state_t;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_FULL  = 2'd2;

  // Control-side register set shared by the stream wrapper; counter widths are capped by the caller.
  localparam int CDC_CNT_MAX_W = 32;

  typedef struct packed {
    cdc_rdstream_state_t        state;
    logic [CDC_CNT_MAX_W-1:0]   xfer_cnt;
    logic [CDC_CNT_MAX_W-1:0]   drop_cnt;
  } cdc_rdstream_regs_t;

  localparam cdc_rdstream_regs_t CDC_RDSTREAM_RST = '{state: RUN, xfer_cnt: '0, drop_cnt: '0};
endpackage

// File: rtl/cdc_skidbuf2.sv
// Two-entry register buffer: slot0 is the head, slot1 absorbs one word of back-pressure.
module cdc_skidbuf2
  import cdc_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [1:0]   o_cnt,
  output logic [W-1:0] o_head
);
  logic [1:0]   cnt_q, cnt_d, wr_idx;
  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;

  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    wr_idx  = cnt_q - {1'b0, i_pop};
    if (i_clr) begin
      cnt_d = SKID_EMPTY;
    end else begin
      cnt_d = cnt_q + {1'b0, i_push} - {1'b0, i_pop};
      if (i_pop) slot0_d = slot1_q;
      // Push lands after the shift, so a push+pop at cnt=1 refills the head directly.
      if (i_push) begin
        if (wr_idx == 2'd0) slot0_d = i_din;
        else                slot1_d = i_din;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= SKID_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_head = slot0_q;
endmodule

// File: rtl/cdc_afifo_rd_stream.sv
// Pops a show-ahead async FIFO and presents the words as a registered valid/ready stream with flush.
module cdc_afifo_rd_stream
  import cdc_pkg::*;
#(
  parameter int dbits = 65,
  parameter int cbits = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rempty,
  input  logic [dbits-1:0] i_rdata,
  output logic             o_rd,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [dbits-1:0] o_data,
  input  logic             i_flush,
  output logic             o_flushing,
  output logic [cbits-1:0] o_xfer_cnt,
  output logic [cbits-1:0] o_drop_cnt
);
  cdc_rdstream_regs_t regs_q, regs_d;
  logic [1:0]         buf_cnt;
  logic               push, pop, clr;

  cdc_skidbuf2 #(.W(dbits)) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (clr),
    .i_push (push),
    .i_pop  (pop),
    .i_din  (i_rdata),
    .o_cnt  (buf_cnt),
    .o_head (o_data)
  );

  assign o_valid    = (buf_cnt != SKID_EMPTY) && (regs_q.state == RUN);
  assign o_flushing = (regs_q.state == FLUSH);
  assign o_xfer_cnt = regs_q.xfer_cnt[cbits-1:0];
  assign o_drop_cnt = regs_q.drop_cnt[cbits-1:0];

  always_comb begin
    regs_d = regs_q;
    push   = 1'b0;
    pop    = 1'b0;
    clr    = 1'b0;
    o_rd   = 1'b0;
    case (regs_q.state)
      RUN: begin
        // Flush wins over a same-cycle handshake: nothing is delivered or popped this cycle.
        if (i_flush) begin
          clr             = 1'b1;
          regs_d.drop_cnt = regs_q.drop_cnt + CDC_CNT_MAX_W'(buf_cnt);
          regs_d.state    = FLUSH;
        end else begin
          push = ~i_rempty && (buf_cnt != SKID_FULL);
          pop  = o_valid && i_ready;
          o_rd = push;
          if (pop) regs_d.xfer_cnt = regs_q.xfer_cnt + 1'b1;
        end
      end
      FLUSH: begin
        o_rd = ~i_rempty;
        if (o_rd) regs_d.drop_cnt = regs_q.drop_cnt + 1'b1;
        if (i_rempty && !i_flush) regs_d.state = RUN;
      end
      default: regs_d.state = RUN;
    endcase
    // Counters are kept at the full package width; truncate so they wrap at 2^cbits.
    regs_d.xfer_cnt = CDC_CNT_MAX_W'(regs_d.xfer_cnt[cbits-1:0]);
    regs_d.drop_cnt = CDC_CNT_MAX_W'(regs_d.drop_cnt[cbits-1:0]);
    if (i_rst) o_rd = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) regs_q <= CDC_RDSTREAM_RST;
    else       regs_q <= regs_d;
  end
endmodule

// File: tb/tb_cdc_afifo_rd_stream.sv
// Scoreboard bench: an ideal show-ahead FIFO model feeds the stream block; a monitor checks delivered words.
module tb_cdc_afifo_rd_stream;
  localparam int DB = 65;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          i_rst, i_rempty, i_ready, i_flush;
  logic [DB-1:0] i_rdata;
  logic          o_rd, o_valid, o_flushing;
  logic [DB-1:0] o_data;
  logic [CB-1:0] o_xfer_cnt, o_drop_cnt;

  logic [DB-1:0] fifo_q[$];
  logic [DB-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  cdc_afifo_rd_stream #(.dbits(DB), .cbits(CB)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_rempty   (i_rempty),
    .i_rdata    (i_rdata),
    .o_rd       (o_rd),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .i_flush    (i_flush),
    .o_flushing (o_flushing),
    .o_xfer_cnt (o_xfer_cnt),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fifo_refresh();
    i_rempty = (fifo_q.size() == 0);
    i_rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endfunction

  task automatic write_word(input logic [DB-1:0] w, input bit delivered);
    fifo_q.push_back(w);
    if (delivered) exp_q.push_back(w);
    fifo_refresh();
  endtask

  // FIFO model: pointer advances on the edge where o_rd is high.
  always @(posedge clk) begin : fifo_model
    bit p;
    p = o_rd;
    #1;
    if (p) begin
      check("rd_on_empty", DB'(fifo_q.size() == 0), DB'(0));
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    fifo_refresh();
  end

  // Monitor: a handshake seen here completes on the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!i_rst && o_valid && i_ready && !i_flush) begin
      if (exp_q.size() == 0) check("unexpected_word", o_data, '0 - 1);
      else check("stream_data", o_data, exp_q.pop_front());
    end
  end

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || o_valid) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, DB'(exp_q.size()), DB'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_pulses, run, c, bad;
    logic [DB-1:0] w;
    i_rst = 1'b1; i_ready = 1'b0; i_flush = 1'b0;
    fifo_refresh();
    repeat (2) @(negedge clk);
    check("rst_valid", DB'(o_valid), DB'(0));
    check("rst_data", o_data, '0);
    check("rst_flushing", DB'(o_flushing), DB'(0));
    check("rst_xfer", DB'(o_xfer_cnt), DB'(0));
    check("rst_drop", DB'(o_drop_cnt), DB'(0));
    i_rst = 1'b0;
    @(negedge clk);

    // 1: full-rate in-order delivery
    i_ready = 1'b1;
    for (int i = 1; i <= 8; i++) write_word(DB'(i), 1'b1);
    drain("t1_drain", 60);
    check("t1_xfer", DB'(o_xfer_cnt), DB'(8));
    check("t1_drop", DB'(o_drop_cnt), DB'(0));

    // 2: back-pressure fills both slots, then back-to-back release
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(DB'(8'h11 + i), 1'b1);
    #1;
    rd_pulses = 0;
    repeat (20) begin
      if (o_rd) rd_pulses++;
      @(negedge clk);
    end
    check("t2_rd_pulses", DB'(rd_pulses), DB'(2));
    check("t2_hold_data", o_data, DB'(8'h11));
    check("t2_hold_valid", DB'(o_valid), DB'(1));
    i_ready = 1'b1;
    run = 0;
    while (o_valid && run < 30) begin
      run++;
      @(negedge clk);
    end
    check("t2_b2b_cycles", DB'(run), DB'(8));
    check("t2_all_out", DB'(exp_q.size()), DB'(0));

    // 3: toggling ready, 100 words
    i_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      w = {1'(i % 2), 32'hC0DE0000 + 32'(i), 32'(i * 7)};
      write_word(w, 1'b1);
    end
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      i_ready = ~i_ready;
      @(negedge clk);
      c++;
    end
    check("t3_done", DB'(exp_q.size()), DB'(0));
    i_ready = 1'b1;
    drain("t3_drain", 20);
    check("t3_xfer", DB'(o_xfer_cnt), DB'(4));

    // 4: flush with two buffered and five queued words
    i_ready = 1'b0;
    for (int i = 0; i < 7; i++) write_word(DB'(8'h41 + i), 1'b0);
    repeat (6) @(negedge clk);
    check("t4_head", o_data, DB'(8'h41));
    i_ready = 1'b1; i_flush = 1'b1;
    #1;
    check("t4_rd_in_flush", DB'(o_rd), DB'(0));
    @(negedge clk);
    i_flush = 1'b0;
    check("t4_flushing", DB'(o_flushing), DB'(1));
    check("t4_no_xfer", DB'(o_xfer_cnt), DB'(4));
    c = 0; bad = 0;
    while (o_flushing && c < 20) begin
      if (o_valid) bad++;
      @(negedge clk);
      c++;
    end
    check("t4_flush_exit", DB'(o_flushing), DB'(0));
    check("t4_valid_low", DB'(bad), DB'(0));
    check("t4_drop", DB'(o_drop_cnt), DB'(7));
    write_word(DB'(8'hAA), 1'b1);
    drain("t4_after", 20);
    check("t4_xfer", DB'(o_xfer_cnt), DB'(5));

    // 5: reset mid-operation with both slots full
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(DB'(8'h31 + i), i >= 2);
    repeat (6) @(negedge clk);
    check("t5_head", o_data, DB'(8'h31));
    i_rst = 1'b1;
    #1;
    check("t5_rd_in_rst", DB'(o_rd), DB'(0));
    @(negedge clk);
    i_rst = 1'b0;
    check("t5_valid", DB'(o_valid), DB'(0));
    check("t5_data", o_data, '0);
    check("t5_xfer", DB'(o_xfer_cnt), DB'(0));
    check("t5_drop", DB'(o_drop_cnt), DB'(0));
    i_ready = 1'b1;
    drain("t5_drain", 30);
    check("t5_xfer_after", DB'(o_xfer_cnt), DB'(4));

    // 6: transfer counter wrap
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    for (int i = 0; i < 17; i++) write_word(DB'(16'h100 + i), 1'b1);
    drain("t6_drain", 60);
    check("t6_xfer_wrap", DB'(o_xfer_cnt), DB'(1));
    check("t6_drop", DB'(o_drop_cnt), DB'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
